issue_scheduler: RTL and testbench

Dual-issue scheduler sitting between the instruction fetch cache and the execute stage. Each cycle it decodes the two-instruction window (instruction0/instruction1) presented by fetch, checks intra-pair and load-use hazards against a load scoreboard, and drives the fetch control inputs: freeze1, freeze2, dependency_on_ins2. Issued instructions go into a registered issue slot pair read by execute; performance counters track dual-issue and stall cycles.

---
 rtl/issue_scheduler_pkg.sv | 42 ++++
 rtl/issue_scheduler_if.sv | 26 ++
 rtl/issue_scheduler_decode.sv | 30 +++
 rtl/issue_scheduler.sv | 94 +++++++++
 tb/tb_issue_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared decode types, RV32I opcode constants and pair-hazard helper for the
// dual-issue scheduler.
package sched_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int unsigned LOAD_LAT_DEF = 2;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       is_load;
    logic       is_mem;
    logic       is_ctrl;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  // Intra-pair conflicts that keep the younger instruction out of slot1.
  function automatic logic pair_blocked(dec_t i0, dec_t i1);
    logic raw;
    logic waw;
    raw = i0.writes_rd &&
          ((i1.uses_rs1 && (i1.rs1 == i0.rd)) || (i1.uses_rs2 && (i1.rs2 == i0.rd)));
    waw = i0.writes_rd && i1.writes_rd && (i1.rd == i0.rd);
    return raw || waw || (i0.is_mem && i1.is_mem) || i0.is_ctrl;
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Fetch-window / issue-slot bus between fetch, scheduler and execute.
interface issue_scheduler_if;
  logic        nothing_filled;
  logic [31:0] instruction0;
  logic [31:0] instruction1;
  logic        ex_ready;
  logic        freeze1;
  logic        freeze2;
  logic        dependency_on_ins2;
  logic        issue0_valid;
  logic        issue1_valid;
  logic [31:0] issue0_instr;
  logic [31:0] issue1_instr;

  modport master (
    output nothing_filled, instruction0, instruction1, ex_ready,
    input  freeze1, freeze2, dependency_on_ins2,
    input  issue0_valid, issue1_valid, issue0_instr, issue1_instr
  );

  modport slave (
    input  nothing_filled, instruction0, instruction1, ex_ready,
    output freeze1, freeze2, dependency_on_ins2,
    output issue0_valid, issue1_valid, issue0_instr, issue1_instr
  );
endinterface

// File: rtl/issue_scheduler_decode.sv
// Combinational RV32I register-usage decoder; an all-zero word is a bubble.
module instr_decode
  import sched_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opc;
  logic       bubble;

  always_comb begin
    opc    = instr[6:0];
    bubble = (instr == '0);
    dec    = '0;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
    dec.uses_rs1 = (opc == OPC_LOAD) || (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
                   (opc == OPC_JALR) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
    dec.uses_rs2 = (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_OP);
    // x0 destinations are folded out here so no hazard check ever sees them.
    dec.writes_rd = !bubble && (opc != OPC_STORE) && (opc != OPC_BRANCH) &&
                    (instr[11:7] != 5'd0);
    dec.is_load = (opc == OPC_LOAD);
    dec.is_mem  = (opc == OPC_LOAD) || (opc == OPC_STORE);
    dec.is_ctrl = (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: pair/load-use hazard checks, fetch control, registered
// issue slots, load scoreboard and performance counters.
module issue_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  issue_scheduler_if.slave bus,
  output logic [CNT_W-1:0] dual_count,
  output logic [CNT_W-1:0] stall_count
);

  dec_t        d0;
  dec_t        d1;
  sb_entry_t   sb [LOAD_LAT];
  sb_entry_t   sb_in;
  logic [31:0] busy_regs;
  logic        empty;
  logic        hz0;
  logic        hz1;
  logic        issue0;
  logic        issue1;

  instr_decode u_dec0 (.instr(bus.instruction0), .dec(d0));
  instr_decode u_dec1 (.instr(bus.instruction1), .dec(d1));

  always_comb begin
    busy_regs = '0;
    for (int unsigned i = 0; i < LOAD_LAT; i++) begin
      if (sb[i].valid) busy_regs[sb[i].rd] = 1'b1;
    end
    busy_regs[0] = 1'b0;
  end

  always_comb begin
    empty  = bus.nothing_filled || (bus.instruction0 == '0);
    hz0    = (d0.uses_rs1 && busy_regs[d0.rs1]) || (d0.uses_rs2 && busy_regs[d0.rs2]);
    hz1    = (d1.uses_rs1 && busy_regs[d1.rs1]) || (d1.uses_rs2 && busy_regs[d1.rs2]);
    issue0 = !empty && bus.ex_ready && !hz0;
    issue1 = issue0 && (bus.instruction1 != '0) && !pair_blocked(d0, d1) && !hz1;

    bus.freeze2            = !empty && !bus.ex_ready;
    bus.freeze1            = !empty && bus.ex_ready && hz0;
    bus.dependency_on_ins2 = issue0 && (bus.instruction1 != '0) && !issue1;

    // Loads never pair (both are memory ops), so at most one enters per cycle.
    sb_in = '0;
    if (issue0 && d0.is_load) begin
      sb_in.valid = 1'b1;
      sb_in.rd    = d0.rd;
    end else if (issue1 && d1.is_load) begin
      sb_in.valid = 1'b1;
      sb_in.rd    = d1.rd;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      for (int unsigned i = 0; i < LOAD_LAT; i++) sb[i] <= '0;
    end else if (en) begin
      sb[0] <= sb_in;
      for (int unsigned i = 1; i < LOAD_LAT; i++) sb[i] <= sb[i-1];
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      bus.issue0_valid <= 1'b0;
      bus.issue1_valid <= 1'b0;
      bus.issue0_instr <= '0;
      bus.issue1_instr <= '0;
    end else if (en && bus.ex_ready) begin
      bus.issue0_valid <= issue0;
      bus.issue1_valid <= issue1;
      bus.issue0_instr <= issue0 ? bus.instruction0 : '0;
      bus.issue1_instr <= issue1 ? bus.instruction1 : '0;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      dual_count  <= '0;
      stall_count <= '0;
    end else if (en) begin
      if (issue1) dual_count <= dual_count + CNT_W'(1);
      if (bus.freeze1 || bus.freeze2) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Randomised scoreboard bench for issue_scheduler against a register-countdown model.
module tb_issue_scheduler;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        en;
  logic [31:0] dual_count;
  logic [31:0] stall_count;

  issue_scheduler_if bus ();

  issue_scheduler #(.LOAD_LAT(LAT), .CNT_W(32)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .en         (en),
    .bus        (bus),
    .dual_count (dual_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] dc;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          busy [32];
  logic        m_v0, m_v1;
  logic [31:0] m_i0, m_i1, m_dc, m_sc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decode written from the ISA register-usage rules.
  function automatic bit reads_reg(logic [31:0] ins, int r);
    logic [6:0] op;
    op = ins[6:0];
    if (r == 0) return 0;
    case (op)
      7'h03, 7'h13, 7'h67: return ins[19:15] == r[4:0];
      7'h23, 7'h63, 7'h33: return (ins[19:15] == r[4:0]) || (ins[24:20] == r[4:0]);
      default:             return 0;
    endcase
  endfunction

  function automatic int dest(logic [31:0] ins);
    if (ins == 0 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63) return 0;
    return int'(ins[11:7]);
  endfunction

  function automatic bit mem_op(logic [31:0] ins);
    return ins[6:0] == 7'h03 || ins[6:0] == 7'h23;
  endfunction

  function automatic bit ctrl_op(logic [31:0] ins);
    return ins[6:0] == 7'h63 || ins[6:0] == 7'h6f || ins[6:0] == 7'h67;
  endfunction

  function automatic bit busy_hz(logic [31:0] ins);
    for (int r = 1; r < 32; r++) if (busy[r] > 0 && reads_reg(ins, r)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) busy[r] = 0;
    m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0; m_dc = 0; m_sc = 0;
    q.delete();
  endtask

  task automatic step(input bit e, input bit nf, input logic [31:0] a, input logic [31:0] b,
                      input bit rdy);
    bit empty, f1, f2, dep, iss0, iss1;
    int d0;
    exp_t x;
    @(negedge clk);
    en = e; bus.nothing_filled = nf; bus.instruction0 = a; bus.instruction1 = b;
    bus.ex_ready = rdy;
    #1;
    empty = nf || (a == 0);
    f1 = 0; f2 = 0; dep = 0; iss0 = 0; iss1 = 0;
    if (!empty) begin
      if (!rdy) f2 = 1;
      else if (busy_hz(a)) f1 = 1;
      else begin
        iss0 = 1;
        d0 = dest(a);
        iss1 = (b != 0) && !(d0 != 0 && reads_reg(b, d0)) && !(d0 != 0 && dest(b) == d0) &&
               !(mem_op(a) && mem_op(b)) && !ctrl_op(a) && !busy_hz(b);
        dep = (b != 0) && !iss1;
      end
    end
    check("freeze1", 32'(bus.freeze1), 32'(f1));
    check("freeze2", 32'(bus.freeze2), 32'(f2));
    check("dependency_on_ins2", 32'(bus.dependency_on_ins2), 32'(dep));
    if (e) begin
      for (int r = 0; r < 32; r++) if (busy[r] > 0) busy[r]--;
      if (iss0 && a[6:0] == 7'h03) busy[dest(a)] = LAT;
      else if (iss1 && b[6:0] == 7'h03) busy[dest(b)] = LAT;
      if (rdy) begin
        m_v0 = iss0; m_i0 = iss0 ? a : 0;
        m_v1 = iss1; m_i1 = iss1 ? b : 0;
      end
      if (iss1) m_dc++;
      if (f1 || f2) m_sc++;
    end
    x.v0 = m_v0; x.v1 = m_v1; x.i0 = m_i0; x.i1 = m_i1; x.dc = m_dc; x.sc = m_sc;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.nothing_filled = 1; bus.instruction0 = 0; bus.instruction1 = 0; bus.ex_ready = 1;
    n_rst = 1;
    #1;
    check("rst_v0", 32'(bus.issue0_valid), 0);
    check("rst_v1", 32'(bus.issue1_valid), 0);
    check("rst_i0", bus.issue0_instr, 0);
    check("rst_i1", bus.issue1_instr, 0);
    check("rst_dual", dual_count, 0);
    check("rst_stall", stall_count, 0);
    check("rst_ctrl", {29'd0, bus.freeze1, bus.freeze2, bus.dependency_on_ins2}, 0);
    model_reset();
    #2 n_rst = 0;
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      check("issue0_valid", 32'(bus.issue0_valid), 32'(x.v0));
      check("issue1_valid", 32'(bus.issue1_valid), 32'(x.v1));
      check("issue0_instr", bus.issue0_instr, x.i0);
      check("issue1_instr", bus.issue1_instr, x.i1);
      check("dual_count", dual_count, x.dc);
      check("stall_count", stall_count, x.sc);
    end
  end

  function automatic logic [31:0] rand_ins();
    logic [4:0] rd, r1, r2;
    rd = 5'($urandom_range(0, 4));
    r1 = 5'($urandom_range(0, 4));
    r2 = 5'($urandom_range(0, 4));
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1, 2:    return {12'h005, r1, 3'b000, rd, 7'h13};
      3:       return {7'h00, r2, r1, 3'b000, rd, 7'h33};
      4, 5:    return {12'h004, r1, 3'b010, rd, 7'h03};
      6:       return {7'h00, r2, r1, 3'b010, 5'h04, 7'h23};
      7:       return {7'h00, r2, r1, 3'b000, 5'h08, 7'h63};
      8:       return {20'h00100, rd, 7'h6f};
      default: return {20'h12345, rd, 7'h37};
    endcase
  endfunction

  localparam logic [31:0] ADDI1 = 32'h00500093;
  localparam logic [31:0] ADDI2 = 32'h00300113;
  localparam logic [31:0] ADDI_DEP = 32'h00108113;
  localparam logic [31:0] LW3   = 32'h00002183;
  localparam logic [31:0] ADD4  = 32'h00318233;
  localparam logic [31:0] BEQ   = 32'h00208463;

  initial begin
    logic [31:0] sc0;
    n_rst = 1; en = 0;
    bus.nothing_filled = 1; bus.instruction0 = 0; bus.instruction1 = 0; bus.ex_ready = 1;
    model_reset();
    do_reset();

    step(1, 0, ADDI1, ADDI2, 1);
    @(posedge clk); #2;
    check("tp_dual_count", dual_count, 1);
    check("tp_dual_v1", 32'(bus.issue1_valid), 1);

    step(1, 0, ADDI1, ADDI_DEP, 1);
    @(posedge clk); #2;
    check("tp_dep_i1", bus.issue1_instr, 0);

    step(1, 0, LW3, 0, 1);
    @(posedge clk); #2;
    sc0 = stall_count;
    step(1, 0, ADD4, 0, 1);
    step(1, 0, ADD4, 0, 1);
    step(1, 0, ADD4, 0, 1);
    @(posedge clk); #2;
    check("tp_loaduse_stalls", stall_count - sc0, 2);
    check("tp_loaduse_issue", bus.issue0_instr, ADD4);

    step(1, 0, ADDI1, ADDI2, 0);
    step(1, 0, BEQ, ADDI2, 1);
    step(0, 0, ADDI1, ADDI2, 1);

    step(1, 0, LW3, 0, 1);
    do_reset();
    step(1, 0, ADD4, 0, 1);

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, rand_ins(), rand_ins(),
           $urandom_range(0, 4) != 0);
    end

    @(posedge clk); #3;
    check("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
